// File: rtl/writeback_arbiter.sv
// -----------------------------------------------------------------------------
// writeback_arbiter
//
// Merges result streams from the ALU and the load unit into a single
// register-file write port through a small in-order writeback buffer.
// Only one source is granted per cycle. When both sources are valid, they
// are served in round-robin order. Results that target x0 complete their
// handshake but are dropped. The buffer head is written on every cycle that
// the buffer is non-empty, because the register file never stalls.
//
// Parameters
//   WIDTH        result / write-port data width
//   FIFO_DEPTH   writeback buffer entries (power of two, >= 2)
//
// Ports
//   clk                       sole clock, rising edge
//   reset                     synchronous, active-high
//   alu_valid / alu_ready     ALU result handshake
//   alu_rd_addr / alu_rd_data ALU destination register and result
//   mem_valid / mem_ready     load-unit result handshake
//   mem_rd_addr / mem_rd_data load destination register and data
//   rd_addr / rd_data         register-file write address and data
//   reg_write                 register-file write enable
//   pending_mask              bit i set while a buffered entry targets xi
//   fifo_count                number of buffered entries
//
// Optional feature
//   WB_BYPASS_EN  when defined, a granted result with a nonzero destination
//                 that arrives while the buffer is empty is written in the
//                 same cycle. It is not enqueued.
// -----------------------------------------------------------------------------
module writeback_arbiter #(
    parameter int WIDTH      = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          alu_valid,
    output logic                          alu_ready,
    input  logic [4:0]                    alu_rd_addr,
    input  logic [WIDTH-1:0]              alu_rd_data,
    input  logic                          mem_valid,
    output logic                          mem_ready,
    input  logic [4:0]                    mem_rd_addr,
    input  logic [WIDTH-1:0]              mem_rd_data,
    output logic [4:0]                    rd_addr,
    output logic [WIDTH-1:0]              rd_data,
    output logic                          reg_write,
    output logic [31:0]                   pending_mask,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Buffer storage (data path, not reset)
    logic [4:0]       r_addr [FIFO_DEPTH];
    logic [WIDTH-1:0] r_data [FIFO_DEPTH];

    // Buffer control
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             r_last_mem;   // 1: mem was the most recent accepted source

    logic             w_fifo_empty;
    logic             w_pop;
    logic             w_space;
    logic             w_grant_alu;
    logic             w_grant_mem;
    logic             w_alu_xfer;
    logic             w_mem_xfer;
    logic             w_xfer;
    logic [4:0]       w_sel_addr;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_bypass;
    logic             w_push;
    logic [31:0]      w_mask;
    logic [PTR_W-1:0] w_idx;

    assign w_fifo_empty = (r_count == '0);

    // The head is written, and therefore popped, on every cycle that the
    // buffer holds an entry. This is suppressed while reset is high because
    // the buffer is being discarded.
    assign w_pop = !w_fifo_empty && !reset;

    // A slot is available if the buffer is not full, or if the head leaves
    // in this same cycle.
    assign w_space = (r_count < CNT_W'(FIFO_DEPTH)) || w_pop;

    // Round robin: on a tie, the source that was not accepted last wins.
    assign w_grant_alu = alu_valid && (!mem_valid || r_last_mem);
    assign w_grant_mem = mem_valid && (!alu_valid || !r_last_mem);

    assign alu_ready = !reset && w_grant_alu && w_space;
    assign mem_ready = !reset && w_grant_mem && w_space;

    assign w_alu_xfer = alu_valid && alu_ready;
    assign w_mem_xfer = mem_valid && mem_ready;
    assign w_xfer     = w_alu_xfer || w_mem_xfer;
    assign w_sel_addr = w_alu_xfer ? alu_rd_addr : mem_rd_addr;
    assign w_sel_data = w_alu_xfer ? alu_rd_data : mem_rd_data;

`ifdef WB_BYPASS_EN
    // Zero-latency path: an empty buffer plus a live result goes straight out.
    assign w_bypass = w_xfer && w_fifo_empty && (w_sel_addr != 5'd0);
`else
    assign w_bypass = 1'b0;
`endif

    // Results that target x0 complete the handshake but are never stored.
    assign w_push = w_xfer && (w_sel_addr != 5'd0) && !w_bypass;

    // Write port: buffer head, the bypassed result, or idle zeros
    always_comb begin
        reg_write = 1'b0;
        rd_addr   = 5'd0;
        rd_data   = '0;
        if (!reset) begin
            if (!w_fifo_empty) begin
                reg_write = 1'b1;
                rd_addr   = r_addr[r_rptr];
                rd_data   = r_data[r_rptr];
            end else if (w_bypass) begin
                reg_write = 1'b1;
                rd_addr   = w_sel_addr;
                rd_data   = w_sel_data;
            end
        end
    end

    // Pending-register scoreboard built from the occupied slots
    always_comb begin
        w_mask = 32'd0;
        w_idx  = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            w_idx = r_rptr + PTR_W'(i);
            if (CNT_W'(i) < r_count) begin
                w_mask[r_addr[w_idx]] = 1'b1;
            end
        end
    end

    assign pending_mask = reset ? 32'd0 : {w_mask[31:1], 1'b0};
    assign fifo_count   = reset ? '0 : r_count;

    // Control state: pointers, occupancy, round-robin history
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_last_mem <= 1'b1;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_alu_xfer) begin
                r_last_mem <= 1'b0;
            end else if (w_mem_xfer) begin
                r_last_mem <= 1'b1;
            end
        end
    end

    // Storage write: the slot at the write pointer takes the accepted result
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wptr] <= w_sel_addr;
            r_data[r_wptr] <= w_sel_data;
        end
    end

endmodule
